// File: rtl/cp0_exc_ctrl_if.sv
// Commit-side bus between the pipeline and the CP0 exception controller.
// Carries the MTC0/MFC0 register port, the commit-stage event inputs and the
// redirect/status outputs.
//   master : pipeline side (drives commit events, consumes flush/read data)
//   slave  : CP0 side
interface cp0_exc_ctrl_if;
    logic        mtc0_we;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic [31:0] mtc0_wdata;
    logic [31:0] mfc0_rdata;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        commit_bd;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        flush;
    logic [31:0] flush_target;
    logic        status_exl;
    logic        int_pending;

    modport master (
        output mtc0_we, cp0_addr, cp0_sel, mtc0_wdata, commit_valid, commit_pc, commit_bd,
               exc_valid, exc_code, exc_badvaddr, eret,
        input  mfc0_rdata, flush, flush_target, status_exl, int_pending
    );

    modport slave (
        input  mtc0_we, cp0_addr, cp0_sel, mtc0_wdata, commit_valid, commit_pc, commit_bd,
               exc_valid, exc_code, exc_badvaddr, eret,
        output mfc0_rdata, flush, flush_target, status_exl, int_pending
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception controller: BadVAddr, Count, Compare, Status, Cause, EPC,
// Count/Compare timer interrupt, sampled external interrupts, commit-stage
// exception/interrupt arbitration, ERET, and a registered one-cycle flush/redirect.
// Ports:
//   clk, rst : core clock, asynchronous active-high reset
//   ext_int  : level-sensitive external interrupt lines (sampled into Cause.IP)
//   bus      : cp0_exc_ctrl_if.slave (MTC0/MFC0 port, commit events, flush outputs)
module cp0_exc_ctrl #(
    parameter int unsigned EXT_INT_W  = 6,
    parameter int unsigned COUNT_DIV  = 2,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [EXT_INT_W-1:0] ext_int,
    cp0_exc_ctrl_if.slave        bus
);
    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(COUNT_DIV - 1);

    logic [31:0]          badvaddr_q, badvaddr_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          compare_q, compare_d;
    logic [31:0]          epc_q, epc_d;
    logic [7:0]           im_q, im_d;
    logic                 exl_q, exl_d;
    logic                 ie_q, ie_d;
    logic                 bd_q, bd_d;
    logic                 ti_q, ti_d;
    logic [1:0]           sw_ip_q, sw_ip_d;
    logic [4:0]           exccode_q, exccode_d;
    logic [EXT_INT_W-1:0] ext_q;
    logic [PW-1:0]        presc_q, presc_d;
    logic                 flush_q, flush_d;
    logic [31:0]          flush_target_q, flush_target_d;

    logic [5:0]  ip_hw;
    logic [31:0] status_val, cause_val, rdata;
    logic        pending, take_int, take_exc, take_eret, reg_wr, count_wr, tick;
    logic [31:0] count_inc;

    // IP7 shares the top external line with the timer interrupt.
    always_comb begin
        ip_hw = '0;
        ip_hw[EXT_INT_W-1:0] = ext_q;
        ip_hw[5] = ip_hw[5] | ti_q;
    end

    assign status_val = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'b0, ip_hw, sw_ip_q, 1'b0, exccode_q, 2'b0};

    assign pending   = ie_q & ~exl_q & |({ip_hw, sw_ip_q} & im_q);
    assign take_int  = bus.commit_valid & pending;
    assign take_exc  = bus.commit_valid & ~pending & bus.exc_valid;
    assign take_eret = bus.commit_valid & ~pending & ~bus.exc_valid & bus.eret;
    assign reg_wr    = bus.commit_valid & ~pending & ~bus.exc_valid & ~bus.eret &
                       bus.mtc0_we & (bus.cp0_sel == 3'd0);
    assign count_wr  = reg_wr & (bus.cp0_addr == 5'd9);
    assign tick      = (presc_q == PMAX);
    assign count_inc = count_q + 32'd1;

    always_comb begin
        rdata = '0;
        if (bus.cp0_sel == 3'd0) begin
            case (bus.cp0_addr)
                5'd8:    rdata = badvaddr_q;
                5'd9:    rdata = count_q;
                5'd11:   rdata = compare_q;
                5'd12:   rdata = status_val;
                5'd13:   rdata = cause_val;
                5'd14:   rdata = epc_q;
                default: rdata = '0;
            endcase
        end
    end

    always_comb begin
        badvaddr_d     = badvaddr_q;
        count_d        = count_q;
        compare_d      = compare_q;
        epc_d          = epc_q;
        im_d           = im_q;
        exl_d          = exl_q;
        ie_d           = ie_q;
        bd_d           = bd_q;
        ti_d           = ti_q;
        sw_ip_d        = sw_ip_q;
        exccode_d      = exccode_q;
        presc_d        = tick ? '0 : presc_q + 1'b1;
        flush_d        = 1'b0;
        flush_target_d = flush_target_q;

        // A Count write overrides the increment, including any TI it would raise.
        if (tick && !count_wr) begin
            count_d = count_inc;
            if (count_inc == compare_q) ti_d = 1'b1;
        end

        if (reg_wr) begin
            case (bus.cp0_addr)
                5'd9: begin
                    count_d = bus.mtc0_wdata;
                    presc_d = '0;
                end
                5'd11: begin
                    compare_d = bus.mtc0_wdata;
                    ti_d      = 1'b0;
                end
                5'd12: begin
                    im_d  = bus.mtc0_wdata[15:8];
                    exl_d = bus.mtc0_wdata[1];
                    ie_d  = bus.mtc0_wdata[0];
                end
                5'd13:   sw_ip_d = bus.mtc0_wdata[9:8];
                5'd14:   epc_d   = bus.mtc0_wdata;
                default: ;
            endcase
        end

        if (take_int || take_exc) begin
            // Nested events keep the original return point.
            if (!exl_q) begin
                epc_d = bus.commit_bd ? bus.commit_pc - 32'd4 : bus.commit_pc;
                bd_d  = bus.commit_bd;
            end
            exl_d     = 1'b1;
            exccode_d = take_int ? 5'd0 : bus.exc_code;
            if (take_exc && (bus.exc_code == 5'd4 || bus.exc_code == 5'd5)) begin
                badvaddr_d = bus.exc_badvaddr;
            end
            flush_d        = 1'b1;
            flush_target_d = EXC_VECTOR;
        end

        if (take_eret) begin
            exl_d          = 1'b0;
            flush_d        = 1'b1;
            flush_target_d = epc_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            badvaddr_q     <= '0;
            count_q        <= '0;
            compare_q      <= '0;
            epc_q          <= '0;
            im_q           <= '0;
            exl_q          <= 1'b0;
            ie_q           <= 1'b0;
            bd_q           <= 1'b0;
            ti_q           <= 1'b0;
            sw_ip_q        <= '0;
            exccode_q      <= '0;
            ext_q          <= '0;
            presc_q        <= '0;
            flush_q        <= 1'b0;
            flush_target_q <= '0;
        end else begin
            badvaddr_q     <= badvaddr_d;
            count_q        <= count_d;
            compare_q      <= compare_d;
            epc_q          <= epc_d;
            im_q           <= im_d;
            exl_q          <= exl_d;
            ie_q           <= ie_d;
            bd_q           <= bd_d;
            ti_q           <= ti_d;
            sw_ip_q        <= sw_ip_d;
            exccode_q      <= exccode_d;
            ext_q          <= ext_int;
            presc_q        <= presc_d;
            flush_q        <= flush_d;
            flush_target_q <= flush_target_d;
        end
    end

    assign bus.mfc0_rdata   = rdata;
    assign bus.flush        = flush_q;
    assign bus.flush_target = flush_target_q;
    assign bus.status_exl   = exl_q;
    assign bus.int_pending  = pending;
endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
- Parametrised coprocessor-0 block for the MIPS core: holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Adds a Count/Compare timer interrupt and a configurable number of hardware interrupt lines.
- Arbitrates exceptions and interrupts presented by the commit stage and handles ERET.
- Sits beside the writeback/commit stage and drives a registered one-cycle pipeline flush with a redirect target.

Parameters:
- EXT_INT_W, 6, number of external interrupt lines, 1..6, mapped to Cause.IP[2+EXT_INT_W-1:2].
- COUNT_DIV, 2, core cycles per Count increment, >=1.
- EXC_VECTOR, 32'hBFC0_0380, flush target for every exception and interrupt.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous active-high reset
- mtc0_we  in  1  MTC0 commit strobe
- cp0_addr  in  5  MTC0/MFC0 register number
- cp0_sel  in  3  MTC0/MFC0 select field
- mtc0_wdata  in  32  MTC0 data
- mfc0_rdata  out  32  combinational read of cp0_addr/cp0_sel
- ext_int  in  EXT_INT_W  level-sensitive external interrupts
- commit_valid  in  1  an instruction is at commit this cycle
- commit_pc  in  32  PC of the committing instruction
- commit_bd  in  1  committing instruction is in a branch delay slot
- exc_valid  in  1  committing instruction raises an exception
- exc_code  in  5  ExcCode (4 AdEL, 5 AdES, 8 Sys, 9 Bp, 10 RI, 12 Ov)
- exc_badvaddr  in  32  faulting address, used only for codes 4/5
- eret  in  1  ERET at commit
- flush  out  1  registered one-cycle redirect pulse
- flush_target  out  32  redirect PC, valid while flush=1
- status_exl  out  1  Status.EXL
- int_pending  out  1  unmasked interrupt is waiting, combinational

Behaviour:
- Reset (async):
  - Status=32'h0040_0000 (BEV=1; IM, EXL, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0; prescaler=0; ext_int sample register=0.
  - flush=0, flush_target=0.
- Register map, sel=0 only. Any sel!=0 ignores writes and reads 0. Unmapped numbers read 0 and ignore writes.
  - 8 BadVAddr: read-only.
  - 9 Count: read/write.
  - 11 Compare: read/write.
  - 12 Status: writable bits [15:8] IM, [1] EXL, [0] IE only.
  - 13 Cause: writable bits [9:8] only.
  - 14 EPC: read/write.
  - All other bits read back constant.
- Cause layout: [31] BD, [30] TI, [15:10] IP7..IP2, [9:8] software IP, [6:2] ExcCode, all others 0.
- Interrupt sampling: ext_int is registered once per cycle into IP[2+EXT_INT_W-1:2]; unused IP bits read 0. IP7 = ext_int bit 5 (if present) OR TI.
- Timer:
  - Prescaler counts 0..COUNT_DIV-1; Count increments (mod 2^32) when the prescaler wraps.
  - TI sets on the cycle Count transitions to a value equal to Compare.
  - TI clears only on an MTC0 to Compare or on reset.
  - MTC0 to Count loads the value and resets the prescaler. A same-cycle increment is dropped.
- int_pending = IE & ~EXL & |(Cause[15:8] & Status[15:8]).
- Commit priority, evaluated at the posedge when commit_valid=1, highest first:
  1. int_pending: take an interrupt (ExcCode=0).
  2. exc_valid: take an exception.
  3. eret.
  4. mtc0_we.
  - A lower-priority item in the same cycle is discarded.
- Taking an interrupt or exception:
  - If EXL=0: EPC = commit_bd ? commit_pc-4 : commit_pc; Cause.BD = commit_bd.
  - If EXL=1: EPC and BD are unchanged.
  - EXL <= 1 and Cause.ExcCode <= code.
  - Codes 4/5 also load BadVAddr.
  - Next cycle: flush=1, flush_target=EXC_VECTOR.
- eret: EXL <= 0; next cycle flush=1, flush_target=EPC (value before any same-edge update).
- flush is high exactly one cycle per accepted event. Back-to-back events give consecutive pulses.
- Events with commit_valid=0 are ignored. Timer and IP sampling continue regardless.
- Reset asserted mid-pulse drops flush immediately.

Test Plan:
- Reset mid-run: assert rst asynchronously -> Status=32'h0040_0000, Cause=0, Count=0, flush=0 with no clock edge.
- Timer interrupt (COUNT_DIV=2):
  - Stimulus: Compare=5, Count=0, Status=32'h0000_8001, commit_valid held 1, commit_pc=32'h8000_0100.
  - Response: TI sets after 10 cycles; next commit gives EPC=32'h8000_0100, ExcCode=0, EXL=1, flush with target 32'hBFC0_0380.
  - Follow-up: MTC0 Compare clears TI.
- Delay-slot exception:
  - Stimulus: exc_valid, code 4, commit_bd=1, commit_pc=32'h8000_0204, exc_badvaddr=32'h0000_1001.
  - Response: EPC=32'h8000_0200, Cause.BD=1, ExcCode=4, BadVAddr=32'h0000_1001.
- Nested exception: Sys with EXL=1 -> ExcCode=8, EPC unchanged, flush to the vector.
- ERET after the delay-slot case -> EXL=0, flush_target=32'h8000_0200.
- Same-cycle conflicts:
  - exc_valid (code 12) + mtc0_we to EPC -> ExcCode=12, MTC0 discarded.
  - Pending interrupt + exc_valid -> ExcCode=0.
  - MTC0 cp0_sel=1 -> no change, read returns 0.
